// File: rtl/pipe_stage_pkg.sv
// Shared defines for pipe_stage: default widths, invalid register address and
// occupancy state encoding.
package pipe_stage_pkg;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_RADDR_W    = 4;
  localparam logic [15:0] DEF_RESULT_RST = 16'h00dd;

  // Truncated to the instance's RADDR_W; all-ones marks "no destination".
  localparam logic [31:0] REG_INVALID = 32'hffff_ffff;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// One pipeline entry: payload register with synchronous clear (flush) taking
// priority over load, and asynchronous active-high reset.
module pipe_payload_reg
  import pipe_stage_pkg::*;
#(
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter int unsigned       RADDR_W    = DEF_RADDR_W,
  parameter logic [DATA_W-1:0] RESULT_RST = DATA_W'(DEF_RESULT_RST)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [DATA_W-1:0]  instr_i,
  input  logic [DATA_W-1:0]  pc_i,
  input  logic [DATA_W-1:0]  result_i,
  input  logic [RADDR_W-1:0] wreg_addr_i,
  input  logic               reg_wrn_i,
  output logic [DATA_W-1:0]  instr_o,
  output logic [DATA_W-1:0]  pc_o,
  output logic [DATA_W-1:0]  result_o,
  output logic [RADDR_W-1:0] wreg_addr_o,
  output logic               reg_wrn_o
);

  localparam logic [RADDR_W-1:0] WregInvalid = RADDR_W'(REG_INVALID);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) begin
      instr_o     <= '0;
      pc_o        <= '0;
      result_o    <= RESULT_RST;
      wreg_addr_o <= WregInvalid;
      reg_wrn_o   <= 1'b0;
    end else if (load_i) begin
      instr_o     <= instr_i;
      pc_o        <= pc_i;
      result_o    <= result_i;
      wreg_addr_o <= wreg_addr_i;
      reg_wrn_o   <= reg_wrn_i;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage with FIFO order. Define PIPE_STAGE_SKID_EN for a
// two-entry skid buffer with registered ready; otherwise single entry.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter int unsigned       RADDR_W    = DEF_RADDR_W,
  parameter logic [DATA_W-1:0] RESULT_RST = DATA_W'(DEF_RESULT_RST)
) (
  input  logic               psi_clk,
  input  logic               psi_rst,
  input  logic               psi_flush,
  input  logic               psi_valid,
  output logic               pso_ready,
  input  logic [DATA_W-1:0]  psi_instr,
  input  logic [DATA_W-1:0]  psi_pc,
  input  logic [DATA_W-1:0]  psi_result,
  input  logic [RADDR_W-1:0] psi_wreg_addr,
  input  logic               psi_reg_wrn,
  output logic               pso_valid,
  input  logic               psi_dn_ready,
  output logic [DATA_W-1:0]  pso_instr,
  output logic [DATA_W-1:0]  pso_pc,
  output logic [DATA_W-1:0]  pso_result,
  output logic [RADDR_W-1:0] pso_wreg_addr,
  output logic               pso_reg_wrn
);

  localparam logic [RADDR_W-1:0] WregInvalid = RADDR_W'(REG_INVALID);

  occ_state_e state_q, state_d;
  logic in_xfer, out_xfer, head_load;
  logic [DATA_W-1:0]  head_instr_d, head_pc_d, head_result_d;
  logic [RADDR_W-1:0] head_wreg_addr_d, head_wreg_addr;
  logic               head_reg_wrn_d, head_reg_wrn;

`ifdef PIPE_STAGE_SKID_EN
  logic skid_load, head_from_skid, ready_q;
  logic [DATA_W-1:0]  skid_instr, skid_pc, skid_result;
  logic [RADDR_W-1:0] skid_wreg_addr;
  logic               skid_reg_wrn;
`endif

  assign in_xfer  = psi_valid && pso_ready;
  assign out_xfer = pso_valid && psi_dn_ready;

  always_comb begin
    state_d   = state_q;
    head_load = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
`endif
    if (psi_flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            state_d   = StBusy;
            head_load = 1'b1;
          end
        end
        StBusy: begin
          if (in_xfer && out_xfer) begin
            head_load = 1'b1;
          end else if (out_xfer) begin
            state_d = StEmpty;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_xfer) begin
            // Downstream stalled: park the newer entry behind the head.
            state_d   = StFull;
            skid_load = 1'b1;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        StFull: begin
          if (out_xfer) begin
            state_d        = StBusy;
            head_load      = 1'b1;
            head_from_skid = 1'b1;
          end
        end
`endif
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge psi_clk or posedge psi_rst) begin
    if (psi_rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Ready is registered so there is no path from psi_dn_ready to pso_ready.
  always_ff @(posedge psi_clk or posedge psi_rst) begin
    if (psi_rst) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d != StFull);
    end
  end
  assign pso_ready = ready_q;

  always_comb begin
    head_instr_d     = head_from_skid ? skid_instr     : psi_instr;
    head_pc_d        = head_from_skid ? skid_pc        : psi_pc;
    head_result_d    = head_from_skid ? skid_result    : psi_result;
    head_wreg_addr_d = head_from_skid ? skid_wreg_addr : psi_wreg_addr;
    head_reg_wrn_d   = head_from_skid ? skid_reg_wrn   : psi_reg_wrn;
  end

  pipe_payload_reg #(
    .DATA_W     (DATA_W),
    .RADDR_W    (RADDR_W),
    .RESULT_RST (RESULT_RST)
  ) u_skid (
    .clk_i       (psi_clk),
    .rst_i       (psi_rst),
    .load_i      (skid_load),
    .clear_i     (psi_flush),
    .instr_i     (psi_instr),
    .pc_i        (psi_pc),
    .result_i    (psi_result),
    .wreg_addr_i (psi_wreg_addr),
    .reg_wrn_i   (psi_reg_wrn),
    .instr_o     (skid_instr),
    .pc_o        (skid_pc),
    .result_o    (skid_result),
    .wreg_addr_o (skid_wreg_addr),
    .reg_wrn_o   (skid_reg_wrn)
  );
`else
  assign pso_ready        = (state_q == StEmpty) || psi_dn_ready;
  assign head_instr_d     = psi_instr;
  assign head_pc_d        = psi_pc;
  assign head_result_d    = psi_result;
  assign head_wreg_addr_d = psi_wreg_addr;
  assign head_reg_wrn_d   = psi_reg_wrn;
`endif

  pipe_payload_reg #(
    .DATA_W     (DATA_W),
    .RADDR_W    (RADDR_W),
    .RESULT_RST (RESULT_RST)
  ) u_head (
    .clk_i       (psi_clk),
    .rst_i       (psi_rst),
    .load_i      (head_load),
    .clear_i     (psi_flush),
    .instr_i     (head_instr_d),
    .pc_i        (head_pc_d),
    .result_i    (head_result_d),
    .wreg_addr_i (head_wreg_addr_d),
    .reg_wrn_i   (head_reg_wrn_d),
    .instr_o     (pso_instr),
    .pc_o        (pso_pc),
    .result_o    (pso_result),
    .wreg_addr_o (head_wreg_addr),
    .reg_wrn_o   (head_reg_wrn)
  );

  assign pso_valid     = (state_q != StEmpty);
  assign pso_reg_wrn   = pso_valid && head_reg_wrn;
  assign pso_wreg_addr = pso_valid ? head_wreg_addr : WregInvalid;

endmodule
